// File: rtl/ahb_bram_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single block-RAM slave.
// m0 is the CPU instruction port and m1 is the data port. A master that
// loses arbitration, or that issues while the slave has no address slot,
// has its address phase held locally. It is then stalled through its own
// HREADY until the slave takes the held transfer.
module ahb_bram_arbiter #(
    parameter int AWIDTH   = 19,
    parameter int ARB_MODE = 0      // 0: round-robin, 1: m1 always wins
) (
    input  logic              sys_clk,
    input  logic              sys_resetn,
    // master 0 (instruction port)
    input  logic [1:0]        m0_htrans,
    input  logic [31:0]       m0_haddr,
    input  logic              m0_hwrite,
    input  logic [1:0]        m0_hsize,
    input  logic [31:0]       m0_hwdata,
    output logic              m0_hready,
    output logic [31:0]       m0_hrdata,
    output logic              m0_hresp,
    // master 1 (data port)
    input  logic [1:0]        m1_htrans,
    input  logic [31:0]       m1_haddr,
    input  logic              m1_hwrite,
    input  logic [1:0]        m1_hsize,
    input  logic [31:0]       m1_hwdata,
    output logic              m1_hready,
    output logic [31:0]       m1_hrdata,
    output logic              m1_hresp,
    // shared slave
    output logic              s_hsel,
    output logic [1:0]        s_htrans,
    output logic [AWIDTH-1:0] s_haddr,
    output logic              s_hwrite,
    output logic [1:0]        s_hsize,
    output logic [31:0]       s_hwdata,
    output logic              s_hready,
    input  logic              s_hreadyout,
    input  logic [31:0]       s_hrdata,
    input  logic              s_hresp
);

    // Per-master views of the two buses, indexed by master number.
    logic [1:0][1:0]        m_htrans;
    logic [1:0][31:0]       m_haddr;
    logic [1:0]             m_hwrite;
    logic [1:0][1:0]        m_hsize;
    logic [1:0][31:0]       m_hwdata;
    logic [1:0]             m_hready;
    logic [1:0]             m_hresp;

    logic [1:0]             live;
    logic [1:0]             req;
    logic [1:0]             pend;
    logic [1:0][AWIDTH-1:0] hold_addr;
    logic [1:0]             hold_write;
    logic [1:0][1:0]        hold_size;

    logic                   rr_last_reg;
    logic                   dph_valid_reg;
    logic                   dph_owner_reg;
    logic                   gnt_valid;
    logic                   gnt_sel;

    assign m_htrans = {m1_htrans, m0_htrans};
    assign m_haddr  = {m1_haddr,  m0_haddr};
    assign m_hwrite = {m1_hwrite, m0_hwrite};
    assign m_hsize  = {m1_hsize,  m0_hsize};
    assign m_hwdata = {m1_hwdata, m0_hwdata};

    assign m0_hready = m_hready[0];
    assign m1_hready = m_hready[1];
    assign m0_hresp  = m_hresp[0];
    assign m1_hresp  = m_hresp[1];
    // Read data is broadcast; only the data-phase owner samples it.
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

    // High address bits and the SEQ/NONSEQ distinction are not used: every
    // forwarded transfer becomes NONSEQ because bursts can be split anywhere.
    logic unused_bits;
    assign unused_bits = ^{m0_haddr[31:AWIDTH], m1_haddr[31:AWIDTH],
                           m0_htrans[0], m1_htrans[0]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic              pend_reg;
            logic [AWIDTH-1:0] hold_addr_reg;
            logic              hold_write_reg;
            logic [1:0]        hold_size_reg;
            logic              owns_dph;

            assign owns_dph      = dph_valid_reg & (dph_owner_reg == 1'(gi));
            // A new address phase is only accepted while this master sees HREADY.
            assign live[gi]      = m_htrans[gi][1] & m_hready[gi];
            assign req[gi]       = pend_reg | live[gi];
            assign m_hready[gi]  = ~pend_reg & ~(owns_dph & ~s_hreadyout);
            assign m_hresp[gi]   = s_hresp & owns_dph;
            assign pend[gi]      = pend_reg;
            assign hold_addr[gi] = hold_addr_reg;
            assign hold_write[gi] = hold_write_reg;
            assign hold_size[gi] = hold_size_reg;

            // Capture a live request that is not forwarded this cycle; release on grant.
            always_ff @(posedge sys_clk or negedge sys_resetn) begin
                if (!sys_resetn) begin
                    pend_reg       <= 1'b0;
                    hold_addr_reg  <= '0;
                    hold_write_reg <= 1'b0;
                    hold_size_reg  <= 2'b00;
                end else if (gnt_valid && gnt_sel == 1'(gi)) begin
                    pend_reg <= 1'b0;
                end else if (live[gi]) begin
                    pend_reg       <= 1'b1;
                    hold_addr_reg  <= m_haddr[gi][AWIDTH-1:0];
                    hold_write_reg <= m_hwrite[gi];
                    hold_size_reg  <= m_hsize[gi];
                end
            end
        end
    endgenerate

    // Pick a winner whenever the slave offers an address slot.
    always_comb begin
        gnt_valid = s_hreadyout & (|req);
        gnt_sel   = 1'b0;
        if (req[0] & req[1]) begin
            gnt_sel = (ARB_MODE == 1) ? 1'b1 : ~rr_last_reg;
        end else begin
            gnt_sel = req[1];
        end
    end

    // Forward the granted address phase, from the hold register if captured.
    always_comb begin
        s_hsel   = gnt_valid;
        s_htrans = gnt_valid ? 2'b10 : 2'b00;
        if (pend[gnt_sel]) begin
            s_haddr  = hold_addr[gnt_sel];
            s_hwrite = hold_write[gnt_sel];
            s_hsize  = hold_size[gnt_sel];
        end else begin
            s_haddr  = m_haddr[gnt_sel][AWIDTH-1:0];
            s_hwrite = m_hwrite[gnt_sel];
            s_hsize  = m_hsize[gnt_sel];
        end
    end

    assign s_hready = s_hreadyout;
    assign s_hwdata = m_hwdata[dph_owner_reg];

    // Track who owns the slave data phase and who was granted last.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            dph_valid_reg <= 1'b0;
            dph_owner_reg <= 1'b0;
            rr_last_reg   <= 1'b1;
        end else if (s_hreadyout) begin
            dph_valid_reg <= gnt_valid;
            if (gnt_valid) begin
                dph_owner_reg <= gnt_sel;
                rr_last_reg   <= gnt_sel;
            end
        end
    end

endmodule

// File: tb/tb_ahb_bram_arbiter.sv
// Bench for ahb_bram_arbiter: directed scenarios followed by random traffic
// from two AHB masters against a scoreboard of transfers and read data.
module tb_ahb_bram_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
    } xfer_t;

    logic             clk = 1'b0;
    logic             sys_resetn;
    logic [1:0][1:0]  htrans;
    logic [1:0][31:0] haddr;
    logic [1:0]       hwrite;
    logic [1:0][1:0]  hsize;
    logic [1:0][31:0] hwdata;
    logic [1:0]       hready;
    logic [1:0][31:0] hrdata;
    logic [1:0]       hresp;
    logic             s_hsel;
    logic [1:0]       s_htrans;
    logic [18:0]      s_haddr;
    logic             s_hwrite;
    logic [1:0]       s_hsize;
    logic [31:0]      s_hwdata;
    logic             s_hready;
    logic             s_hreadyout;
    logic [31:0]      s_hrdata;
    logic             s_hresp;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: master-side view and slave-side view.
    logic [1:0]       cur_v, cur_wr, dp_v, dp_wr;
    logic [1:0][31:0] cur_addr, cur_wd, dp_wd;
    logic             sdp_v, sdp_wr;
    int               sdp_m;
    logic [31:0]      sdp_wd;
    xfer_t            iss_q [2][$];
    logic [31:0]      rd_q  [2][$];

    ahb_bram_arbiter #(.AWIDTH(19), .ARB_MODE(0)) dut (
        .sys_clk(clk), .sys_resetn(sys_resetn),
        .m0_htrans(htrans[0]), .m0_haddr(haddr[0]), .m0_hwrite(hwrite[0]),
        .m0_hsize(hsize[0]), .m0_hwdata(hwdata[0]), .m0_hready(hready[0]),
        .m0_hrdata(hrdata[0]), .m0_hresp(hresp[0]),
        .m1_htrans(htrans[1]), .m1_haddr(haddr[1]), .m1_hwrite(hwrite[1]),
        .m1_hsize(hsize[1]), .m1_hwdata(hwdata[1]), .m1_hready(hready[1]),
        .m1_hrdata(hrdata[1]), .m1_hresp(hresp[1]),
        .s_hsel(s_hsel), .s_htrans(s_htrans), .s_haddr(s_haddr),
        .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hwdata(s_hwdata),
        .s_hready(s_hready), .s_hreadyout(s_hreadyout),
        .s_hrdata(s_hrdata), .s_hresp(s_hresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            htrans[i] = 2'b00;
            haddr[i]  = 32'h0;
            hwrite[i] = 1'b0;
            hsize[i]  = 2'b10;
            hwdata[i] = 32'h0;
        end
        s_hreadyout = 1'b1;
        s_hrdata    = 32'h0;
        s_hresp     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        sys_resetn = 1'b0;
        repeat (2) @(negedge clk);
        sys_resetn = 1'b1;
    endtask

    // One cycle of random traffic: drive at negedge, check and advance the model.
    task automatic rand_cycle(input bit issue);
        int          m;
        xfer_t       x;
        logic [31:0] a;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            htrans[i] = cur_v[i] ? 2'b10 : 2'b00;
            haddr[i]  = cur_addr[i];
            hwrite[i] = cur_wr[i];
            hsize[i]  = 2'b10;
            hwdata[i] = dp_v[i] ? dp_wd[i] : $urandom;
        end
        s_hreadyout = sdp_v ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_hrdata    = $urandom;
        s_hresp     = 1'b0;
        #1;
        // slave data phase completes
        if (sdp_v && s_hreadyout) begin
            if (sdp_wr) chk("s_hwdata", s_hwdata, sdp_wd);
            else rd_q[sdp_m].push_back(s_hrdata);
            sdp_v = 1'b0;
        end
        // masters: data phase completion and address acceptance
        for (int i = 0; i < 2; i++) begin
            chk("m_hresp_quiet", 32'(hresp[i]), 32'd0);
            if (hready[i]) begin
                if (dp_v[i] && !dp_wr[i]) begin
                    chk("rd_served", rd_q[i].size(), 32'd1);
                    if (rd_q[i].size() != 0) chk("m_hrdata", hrdata[i], rd_q[i].pop_front());
                end
                if (dp_v[i] && dp_wr[i]) chk("wr_served", 32'(sdp_v && sdp_m == i), 32'd0);
                dp_v[i]  = cur_v[i];
                dp_wr[i] = cur_wr[i];
                dp_wd[i] = cur_wd[i];
                if (cur_v[i]) begin
                    x.addr = cur_addr[i]; x.wr = cur_wr[i]; x.wd = cur_wd[i];
                    iss_q[i].push_back(x);
                end
                if (issue && $urandom_range(0, 9) < 7) begin
                    a = $urandom;
                    a[18] = i[0];
                    a[1:0] = 2'b00;
                    cur_addr[i] = a;
                    cur_wr[i]   = 1'($urandom_range(0, 1));
                    cur_wd[i]   = $urandom;
                    cur_v[i]    = 1'b1;
                end else begin
                    cur_v[i] = 1'b0;
                end
            end
        end
        // slave address phase
        if (!s_hreadyout) begin
            chk("no_slot_idle", 32'(s_htrans), 32'd0);
        end else if (s_htrans != 2'b00) begin
            chk("s_htrans_nonseq", 32'(s_htrans), 32'h2);
            chk("s_hsel", 32'(s_hsel), 32'd1);
            m = int'(s_haddr[18]);
            chk("expected_xfer", iss_q[m].size(), 32'd1);
            if (iss_q[m].size() != 0) begin
                x = iss_q[m].pop_front();
                chk("s_haddr", 32'(s_haddr), 32'(x.addr[18:0]));
                chk("s_hwrite", 32'(s_hwrite), 32'(x.wr));
                chk("s_hsize", 32'(s_hsize), 32'h2);
                sdp_v  = 1'b1;
                sdp_m  = m;
                sdp_wr = x.wr;
                sdp_wd = x.wd;
            end
        end
    endtask

    initial begin
        idle_all();
        sys_resetn = 1'b0;
        #1;
        // reset state
        chk("rst_m0_hready", 32'(hready[0]), 32'd1);
        chk("rst_m1_hready", 32'(hready[1]), 32'd1);
        chk("rst_m0_hresp", 32'(hresp[0]), 32'd0);
        chk("rst_s_htrans", 32'(s_htrans), 32'd0);
        chk("rst_s_hsel", 32'(s_hsel), 32'd0);
        do_reset();

        // single m0 read, zero added latency
        @(negedge clk);
        htrans[0] = 2'b10; haddr[0] = 32'h100;
        #1;
        chk("t1_s_haddr", 32'(s_haddr), 32'h100);
        chk("t1_s_htrans", 32'(s_htrans), 32'h2);
        chk("t1_m1_hready", 32'(hready[1]), 32'd1);
        @(negedge clk);
        htrans[0] = 2'b00; s_hrdata = 32'h1234_5678;
        #1;
        chk("t1_m0_hready", 32'(hready[0]), 32'd1);
        chk("t1_m0_hrdata", hrdata[0], 32'h1234_5678);
        chk("t1_m1_hready_b", 32'(hready[1]), 32'd1);
        chk("t1_idle", 32'(s_htrans), 32'd0);

        // simultaneous m0 read / m1 write: m0 wins the first tie
        do_reset();
        @(negedge clk);
        htrans[0] = 2'b10; haddr[0] = 32'h0;
        htrans[1] = 2'b10; haddr[1] = 32'h40; hwrite[1] = 1'b1;
        #1;
        chk("t2_s_haddr_m0", 32'(s_haddr), 32'h0);
        chk("t2_s_hwrite_m0", 32'(s_hwrite), 32'd0);
        @(negedge clk);
        htrans[0] = 2'b00; htrans[1] = 2'b00; hwrite[1] = 1'b0;
        hwdata[0] = 32'h1111_1111; hwdata[1] = 32'hDEAD_BEEF;
        #1;
        chk("t2_s_haddr_m1", 32'(s_haddr), 32'h40);
        chk("t2_s_hwrite_m1", 32'(s_hwrite), 32'd1);
        chk("t2_s_htrans_m1", 32'(s_htrans), 32'h2);
        chk("t2_m1_stall", 32'(hready[1]), 32'd0);
        chk("t2_m0_done", 32'(hready[0]), 32'd1);
        @(negedge clk);
        #1;
        chk("t2_s_hwdata", s_hwdata, 32'hDEAD_BEEF);
        chk("t2_m1_done", 32'(hready[1]), 32'd1);

        // both masters continuously reading: strict alternation
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            htrans[0] = 2'b10; haddr[0] = 32'h1000;
            htrans[1] = 2'b10; haddr[1] = 32'h2000;
            #1;
            chk("t3_alt_addr", 32'(s_haddr), (k % 2 == 0) ? 32'h1000 : 32'h2000);
            if (k > 0) begin
                chk("t3_m0_hready", 32'(hready[0]), 32'(k % 2));
                chk("t3_m1_hready", 32'(hready[1]), 32'(1 - k % 2));
            end
        end

        // m0 captured behind a stalled m1 data phase
        do_reset();
        @(negedge clk);
        htrans[1] = 2'b10; haddr[1] = 32'h300;
        #1;
        chk("t4_m1_addr", 32'(s_haddr), 32'h300);
        @(negedge clk);
        htrans[1] = 2'b00; s_hreadyout = 1'b0;
        htrans[0] = 2'b10; haddr[0] = 32'h200;
        #1;
        chk("t4_m1_wait", 32'(hready[1]), 32'd0);
        chk("t4_no_slot", 32'(s_htrans), 32'd0);
        @(negedge clk);
        htrans[0] = 2'b00;
        #1;
        chk("t4_m0_stall", 32'(hready[0]), 32'd0);
        chk("t4_no_slot_b", 32'(s_htrans), 32'd0);
        @(negedge clk);
        s_hreadyout = 1'b1; s_hrdata = 32'hCAFE_0001;
        #1;
        chk("t4_held_addr", 32'(s_haddr), 32'h200);
        chk("t4_held_htrans", 32'(s_htrans), 32'h2);
        chk("t4_m1_done", 32'(hready[1]), 32'd1);
        chk("t4_m1_rdata", hrdata[1], 32'hCAFE_0001);
        chk("t4_m0_still", 32'(hready[0]), 32'd0);
        @(negedge clk);
        #1;
        chk("t4_m0_done", 32'(hready[0]), 32'd1);

        // ERROR response routed to m1 only; IDLE in the second cycle is not queued
        do_reset();
        @(negedge clk);
        htrans[1] = 2'b10; haddr[1] = 32'h400;
        @(negedge clk);
        htrans[1] = 2'b00; s_hreadyout = 1'b0; s_hresp = 1'b1;
        #1;
        chk("t5_err1_resp", 32'(hresp[1]), 32'd1);
        chk("t5_err1_ready", 32'(hready[1]), 32'd0);
        chk("t5_err1_m0", 32'(hresp[0]), 32'd0);
        @(negedge clk);
        s_hreadyout = 1'b1;
        #1;
        chk("t5_err2_resp", 32'(hresp[1]), 32'd1);
        chk("t5_err2_ready", 32'(hready[1]), 32'd1);
        chk("t5_err2_m0", 32'(hresp[0]), 32'd0);
        chk("t5_err2_noacc", 32'(s_htrans), 32'd0);
        @(negedge clk);
        s_hresp = 1'b0;
        #1;
        chk("t5_after_noacc", 32'(s_htrans), 32'd0);
        chk("t5_after_resp", 32'(hresp[1]), 32'd0);

        // reset while m1 has a held request
        do_reset();
        @(negedge clk);
        htrans[0] = 2'b10; haddr[0] = 32'h500;
        htrans[1] = 2'b10; haddr[1] = 32'h600;
        @(negedge clk);
        htrans[0] = 2'b00; htrans[1] = 2'b00;
        #1;
        chk("t6_pending", 32'(hready[1]), 32'd0);
        sys_resetn = 1'b0;
        #1;
        chk("t6_rst_hready", 32'(hready[1]), 32'd1);
        chk("t6_rst_htrans", 32'(s_htrans), 32'd0);
        @(negedge clk);
        sys_resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("t6_no_stale", 32'(s_htrans), 32'd0);
        end

        // random traffic against the scoreboard
        do_reset();
        cur_v = '0; cur_wr = '0; dp_v = '0; dp_wr = '0;
        cur_addr = '0; cur_wd = '0; dp_wd = '0;
        sdp_v = 1'b0; sdp_wr = 1'b0; sdp_m = 0; sdp_wd = '0;
        for (int c = 0; c < 1500; c++) rand_cycle(1'b1);
        for (int c = 0; c < 60 && ((|cur_v) || (|dp_v) || sdp_v); c++) rand_cycle(1'b0);
        chk("drain_done", 32'((|cur_v) || (|dp_v) || sdp_v), 32'd0);
        chk("iss_q0_empty", iss_q[0].size(), 32'd0);
        chk("iss_q1_empty", iss_q[1].size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
